// File: rtl/shift_unit_seq.sv
// Sequential shifter that moves the operand one bit per clock for shamt cycles.
// Optional rotate-right for op 100 is enabled by defining SHIFT_ROR_EN.
module shift_unit_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] data_in,
    input  logic [4:0]  shamt,
    output logic [31:0] saida,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

    state_t      state, state_nxt;
    logic [4:0]  count;
    logic [2:0]  op_q;
    logic [31:0] step;

    // One-bit step of the latched op; unknown ops hold the value so timing is op-independent.
    always_comb begin
        step = saida;
        case (op_q)
            3'b001:  step = {saida[30:0], 1'b0};
            3'b010:  step = {1'b0, saida[31:1]};
            3'b011:  step = {saida[31], saida[31:1]};
`ifdef SHIFT_ROR_EN
            3'b100:  step = {saida[0], saida[31:1]};
`endif
            default: step = saida;
        endcase
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (count == 5'd0)
                    state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            saida <= 32'd0;
            count <= 5'd0;
            op_q  <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        saida <= data_in;
                        count <= shamt;
                        op_q  <= op;
                    end
                end
                SHIFT: begin
                    if (count != 5'd0) begin
                        saida <= step;
                        count <= count - 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_unit_seq.sv
// Randomized self-checking bench for shift_unit_seq against a whole-shift arithmetic model.
`timescale 1ns/1ps
module tb_shift_unit_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic [31:0] saida;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    shift_unit_seq dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .data_in(data_in),
        .shamt(shamt), .saida(saida), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Whole shift computed in one go from the op rules.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] d, input logic [4:0] s);
        logic [31:0] r;
        case (o)
            3'b001: r = d << s;
            3'b010: r = d >> s;
            3'b011: r = 32'($signed(d) >>> s);
`ifdef SHIFT_ROR_EN
            3'b100: r = (s == 5'd0) ? d : ((d >> s) | (d << (32 - int'(s))));
`endif
            default: r = d;
        endcase
        return r;
    endfunction

    // Called at a negedge; leaves the DUT back in IDLE at a negedge.
    task automatic run_op(input logic [2:0] o, input logic [31:0] d, input logic [4:0] s,
                          output logic [31:0] res, output int lat, output int bcnt,
                          output logic post_busy, output logic post_done, output logic [31:0] post_saida);
        start = 1'b1; op = o; data_in = d; shamt = s;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0; bcnt = 0;
        while (!done && lat < 100) begin
            if (busy) bcnt++;
            op = 3'($urandom_range(0, 7)); data_in = $urandom; shamt = 5'($urandom);
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        res = saida;
        @(posedge clk);
        @(negedge clk);
        post_busy = busy; post_done = done; post_saida = saida;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; op = 3'b001; data_in = 32'hFFFF_FFFF; shamt = 5'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++; if (saida !== 32'd0) begin n_fail++; $display("FAIL reset_saida got=%h exp=0", saida); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sll_basic();
        logic [31:0] r, ps; int lat, bc; logic pb, pd;
        run_op(3'b001, 32'h0000_0001, 5'd4, r, lat, bc, pb, pd, ps);
        n_tests++; if (r !== 32'h0000_0010) begin n_fail++; $display("FAIL sll_result got=%h exp=00000010", r); end
        n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL sll_latency got=%0d exp=5", lat); end
        n_tests++; if (bc !== 5) begin n_fail++; $display("FAIL sll_busy_cycles got=%0d exp=5", bc); end
        n_tests++; if (pb !== 1'b0 || pd !== 1'b0) begin n_fail++; $display("FAIL sll_idle_after got busy=%b done=%b exp 0 0", pb, pd); end
        n_tests++; if (ps !== 32'h0000_0010) begin n_fail++; $display("FAIL sll_hold got=%h exp=00000010", ps); end
    endtask

    task automatic test_sra_srl();
        logic [31:0] r, ps; int lat, bc; logic pb, pd;
        run_op(3'b011, 32'h8000_0000, 5'd31, r, lat, bc, pb, pd, ps);
        n_tests++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sra_31 got=%h exp=ffffffff", r); end
        n_tests++; if (lat !== 32) begin n_fail++; $display("FAIL sra_latency got=%0d exp=32", lat); end
        run_op(3'b010, 32'h8000_0000, 5'd31, r, lat, bc, pb, pd, ps);
        n_tests++; if (r !== 32'h0000_0001) begin n_fail++; $display("FAIL srl_31 got=%h exp=00000001", r); end
    endtask

    task automatic test_zero_shamt();
        logic [31:0] r, ps; int lat, bc; logic pb, pd;
        run_op(3'b001, 32'hDEAD_BEEF, 5'd0, r, lat, bc, pb, pd, ps);
        n_tests++; if (r !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL zero_shamt_result got=%h exp=deadbeef", r); end
        n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL zero_shamt_latency got=%0d exp=1", lat); end
    endtask

    task automatic test_ignore_start();
        int pulses = 0;
        start = 1'b1; op = 3'b001; data_in = 32'h0000_0001; shamt = 5'd3;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            if (done) pulses++;
            // Re-request once in SHIFT and again in the DONE cycle.
            start = (i == 1) || done;
            op = 3'b010; data_in = $urandom | 32'h1; shamt = 5'd1;
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
        n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL ignore_done_pulses got=%0d exp=1", pulses); end
        n_tests++; if (saida !== 32'h0000_0008) begin n_fail++; $display("FAIL ignore_result got=%h exp=00000008", saida); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] r, ps, d; int lat, bc; logic pb, pd; int pulses = 0;
        start = 1'b1; op = 3'b001; data_in = 32'h0000_00FF; shamt = 5'd10;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) begin
            if (done) pulses++;
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (done) pulses++;
        n_tests++; if (saida !== 32'd0) begin n_fail++; $display("FAIL abort_saida got=%h exp=0", saida); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy); end
        n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL abort_done_pulses got=%0d exp=0", pulses); end
        reset = 1'b0;
        d = $urandom;
        run_op(3'b010, d, 5'd7, r, lat, bc, pb, pd, ps);
        n_tests++; if (r !== (d >> 7)) begin n_fail++; $display("FAIL post_reset_result got=%h exp=%h", r, d >> 7); end
        n_tests++; if (lat !== 8) begin n_fail++; $display("FAIL post_reset_latency got=%0d exp=8", lat); end
    endtask

    task automatic test_ror();
        logic [31:0] r, ps, e; int lat, bc; logic pb, pd;
`ifdef SHIFT_ROR_EN
        e = 32'h8000_0001;
`else
        e = 32'h0000_0003;
`endif
        run_op(3'b100, 32'h0000_0003, 5'd1, r, lat, bc, pb, pd, ps);
        n_tests++; if (r !== e) begin n_fail++; $display("FAIL ror_result got=%h exp=%h", r, e); end
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL ror_latency got=%0d exp=2", lat); end
    endtask

    task automatic test_random();
        logic [31:0] r, ps, d, e; int lat, bc; logic pb, pd; logic [2:0] o; logic [4:0] s;
        for (int i = 0; i < 24; i++) begin
            o = 3'($urandom_range(0, 7)); d = $urandom; s = 5'($urandom);
            e = model(o, d, s);
            run_op(o, d, s, r, lat, bc, pb, pd, ps);
            n_tests++;
            if (r !== e || lat !== int'(s) + 1 || bc !== int'(s) + 1 || pb !== 1'b0 || ps !== e) begin
                n_fail++;
                $display("FAIL random op=%0d d=%h s=%0d got=%h lat=%0d busy=%0d exp=%h lat=%0d", o, d, s, r, lat, bc, e, int'(s) + 1);
            end
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = 3'b000; data_in = 32'd0; shamt = 5'd0;
        @(negedge clk);
        test_reset();
        test_sll_basic();
        test_sra_srl();
        test_zero_shamt();
        test_ignore_start();
        test_reset_abort();
        test_ror();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/shift_unit_seq.md
SHIFT_UNIT_SEQ -- requirements
Module: shift_unit_seq

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port start, input, 1 bit: request pulse, sampled only in IDLE.
REQ-004 The block SHALL have port op, input, 3 bits: 000 load, 001 SLL, 010 SRL, 011 SRA, 100 ROR (see REQ-024).
REQ-005 The block SHALL have port data_in, input, 32 bits: operand, captured on the edge that accepts start.
REQ-006 The block SHALL have port shamt, input, 5 bits: shift count 0..31, captured on the edge that accepts start.
REQ-007 The block SHALL have port saida, output, 32 bits: shift register contents; this drives the ALU-B mux RegDeslocamento input.
REQ-008 The block SHALL have port busy, output, 1 bit: high in SHIFT and DONE states.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle completion pulse, high only in DONE state.

Function
REQ-010 The block SHALL implement an FSM with states IDLE, SHIFT, DONE.
REQ-011 In IDLE with start=1, the clock edge SHALL load saida<=data_in, count<=shamt, latch op, and move to SHIFT.
REQ-012 In SHIFT with count!=0, each edge SHALL shift saida by exactly one bit per the latched op and decrement count.
REQ-013 In SHIFT with count==0, the edge SHALL hold saida and move to DONE.
REQ-014 In DONE, the next edge SHALL return to IDLE unconditionally.
REQ-015 Latency: start accepted at edge k SHALL produce done=1 in the cycle after edge k+shamt+1; shamt=0 gives done in the cycle after edge k+1.
REQ-016 SLL SHALL fill bit 0 with 0.
REQ-017 SRL SHALL fill bit 31 with 0.
REQ-018 SRA SHALL fill bit 31 with the current bit 31.
REQ-019 Op load and ops 101..111 SHALL leave saida unchanged while count still decrements, so timing stays identical.
REQ-020 start while busy=1 SHALL be ignored, including during the DONE cycle; data_in, shamt and op changes while busy SHALL have no effect.
REQ-021 saida SHALL hold its last result in IDLE until the next accepted start.

Reset
REQ-022 reset=1 at an edge SHALL force state IDLE, saida=0, count=0, latched op=000, busy=0 and done=0; it SHALL have priority over start.
REQ-023 reset asserted mid-operation (SHIFT or DONE) SHALL abort without a done pulse; start in the first cycle after reset deasserts SHALL be accepted.

Configuration
REQ-024 With macro SHIFT_ROR_EN defined, op 100 SHALL rotate right one bit per step, with bit 0 moving to bit 31; without it, op 100 SHALL behave as load per REQ-019.

Verification
REQ-025 The bench SHALL cover: reset; start, op=001, data_in=0x0000_0001, shamt=4 -> done in the cycle after edge k+5, saida=0x0000_0010, busy high for 5 cycles.
REQ-026 The bench SHALL cover: op=011, data_in=0x8000_0000, shamt=31 -> saida=0xFFFF_FFFF; op=010 with the same inputs -> saida=0x0000_0001.
REQ-027 The bench SHALL cover: op=001, shamt=0, data_in=0xDEAD_BEEF -> done in the cycle after edge k+1, saida=0xDEAD_BEEF.
REQ-028 The bench SHALL cover: start pulsed again with a different data_in during SHIFT and during DONE -> ignored, result unchanged, exactly one done pulse.
REQ-029 The bench SHALL cover: reset asserted 2 cycles into a shamt=10 shift -> saida=0, busy=0, no done pulse; a new start on the next cycle completes normally.
REQ-030 The bench SHALL cover: op=100, data_in=0x0000_0003, shamt=1 -> saida=0x8000_0001 with SHIFT_ROR_EN, saida=0x0000_0003 without it.
